fetch_pc_unit: RTL

Parametrised fetch-PC stage for the IF pipeline: holds the architectural fetch PC, expands it into a FETCH_WIDTH-wide group of per-slot virtual addresses for the BTB/ICache, and advances on a ready handshake. It applies backend flushes and branch redirects, including the MIPS case where a redirecting branch's delay slot has not yet been fetched. It sits between the backend redirect sources and the BTB/ICache request port.

---
 rtl/fetch_pc_unit_pkg.sv | 26 ++
 rtl/fetch_pc_unit_pc_slot_expand.sv | 37 +++
 rtl/fetch_pc_unit.sv | 108 ++++++++++
 3 files changed

// File: rtl/fetch_pc_unit_pkg.sv
// Shared types and defaults for the fetch-PC stage.
// Optional build macro: PCG_ALIGN_CHECK_EN.
`ifndef SINGLE_WORD
`define SINGLE_WORD 32
`endif

package fetch_pc_unit_pkg;

  localparam int XLEN = `SINGLE_WORD;

  localparam logic [XLEN-1:0] PCG_RESET_PC =
    32'hbfc00000;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_DS  = 1'b1
  } pcg_state_e;

  function automatic logic [XLEN-1:0] slot_idx(
    input logic [XLEN-1:0] pc,
    input int              fw
  );
    return (pc >> 2) & XLEN'(fw - 1);
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_slot_expand.sv
// Expands the fetch PC into per-slot addresses and a slot mask.
// Purely combinational; no registers.
module pc_slot_expand
  import fetch_pc_unit_pkg::*;
#(
  parameter int FETCH_WIDTH = 4
) (
  input  logic [XLEN-1:0]             pc_i,
  input  logic                        ds_i,
  output logic [FETCH_WIDTH*XLEN-1:0] vaddr_o,
  output logic [FETCH_WIDTH-1:0]      mask_o
);

  localparam logic [XLEN-1:0] GRP_MASK =
    XLEN'(FETCH_WIDTH * 4 - 1);

  logic [XLEN-1:0] base;
  logic [XLEN-1:0] idx;

  assign base = pc_i & ~GRP_MASK;
  assign idx  = slot_idx(pc_i, FETCH_WIDTH);

  always_comb begin
    vaddr_o = '0;
    mask_o  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      vaddr_o[i*XLEN +: XLEN] =
        base | XLEN'(i * 4)
             | {{(XLEN-2){1'b0}}, pc_i[1:0]};
      if (ds_i)
        mask_o[i] = (XLEN'(i) == idx);
      else
        mask_o[i] = (XLEN'(i) >= idx);
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-PC stage: holds PC, applies flush/redirect, issues groups.
// Optional build macro: PCG_ALIGN_CHECK_EN.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter int              FETCH_WIDTH = 4,
  parameter logic [XLEN-1:0] RESET_PC    = PCG_RESET_PC
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        BE_flush_i,
  input  logic [XLEN-1:0]             BE_flushTarget_i,
  input  logic                        BR_redirect_i,
  input  logic [XLEN-1:0]             BR_target_i,
  input  logic                        BR_needDelaySlot_i,
  input  logic [XLEN-1:0]             BR_delaySlotPC_i,
  input  logic                        IC_ready_i,
  output logic                        PCG_valid_o,
  output logic [FETCH_WIDTH*XLEN-1:0] PCG_VAddr_p_o,
  output logic [FETCH_WIDTH-1:0]      PCG_slotMask_o,
  output logic                        PCG_isDelaySlotGroup_o,
  output logic                        PCG_adel_o
);

  localparam logic [XLEN-1:0] STEP =
    XLEN'(FETCH_WIDTH * 4);

  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] tgt_q, tgt_d;
  pcg_state_e      st_q, st_d;
  logic            valid_q, valid_d;

  logic [FETCH_WIDTH-1:0] raw_mask;
  logic [FETCH_WIDTH-1:0] one_hot;
  logic                   fire;
  logic                   adel;
  logic                   advance;

  pc_slot_expand #(
    .FETCH_WIDTH(FETCH_WIDTH)
  ) u_expand (
    .pc_i    (pc_q),
    .ds_i    (st_q == ST_DS),
    .vaddr_o (PCG_VAddr_p_o),
    .mask_o  (raw_mask)
  );

`ifdef PCG_ALIGN_CHECK_EN
  assign adel = valid_q & (pc_q[1:0] != 2'b00);
`else
  assign adel = 1'b0;
`endif

  assign one_hot = FETCH_WIDTH'(1)
    << slot_idx(pc_q, FETCH_WIDTH);
  assign fire    = valid_q & IC_ready_i;
  // A faulting group must be flushed, never advanced past.
  assign advance = fire & ~adel;

  always_comb begin
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    st_d    = st_q;
    valid_d = 1'b1;
    if (advance) begin
      if (st_q == ST_DS) begin
        pc_d = tgt_q;
        st_d = ST_RUN;
      end else begin
        pc_d = (pc_q & ~(STEP - 1)) + STEP;
      end
    end
    if (BE_flush_i) begin
      pc_d = BE_flushTarget_i;
      st_d = ST_RUN;
    end else if (BR_redirect_i
                 && BR_needDelaySlot_i) begin
      pc_d  = BR_delaySlotPC_i;
      tgt_d = BR_target_i;
      st_d  = ST_DS;
    end else if (BR_redirect_i) begin
      pc_d = BR_target_i;
      st_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q    <= RESET_PC;
      tgt_q   <= '0;
      st_q    <= ST_RUN;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      st_q    <= st_d;
      valid_q <= valid_d;
    end
  end

  assign PCG_valid_o    = valid_q;
  assign PCG_adel_o     = adel;
  assign PCG_slotMask_o =
    !valid_q ? '0 : (adel ? one_hot : raw_mask);
  assign PCG_isDelaySlotGroup_o =
    valid_q & (st_q == ST_DS);

endmodule
